fsm_seq_gen: RTL
================

Name: fsm_seq_gen

Overview:
Parametrised, programmable state sequencer and the successor to the fixed mod-6 output FSM.
- Steps a WIDTH-bit state value through 0..MODULUS-1.
- Runtime modes: up, down, ping-pong, hold.
- Controls: enable, synchronous clear, parallel load with range clamping.
- Status: terminal-count strobe and saturating completed-cycle counter.
- Drives sequencing/select buses in datapath exercises, replacing hard-wired counter FSMs.

Parameters:
WIDTH, 3, width of state value fout.
MODULUS, 6, sequence length; legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.
CYC_W, 8, width of completed-cycle counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
en  in  1  step enable.
clr  in  1  synchronous clear.
load  in  1  synchronous parallel load.
load_val  in  WIDTH  value to load.
mode  in  2  00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD.
fout  out  WIDTH  current state value, registered.
dir  out  1  direction state: 1 = UP, 0 = DOWN, registered.
tc  out  1  terminal count, combinational from registers and inputs.
load_err  out  1  one-cycle flag: last load was clamped, registered.
cyc_cnt  out  CYC_W  completed sequence cycles, saturating, registered.

Behaviour:
- Reset: rst=0 immediately (no clock edge needed) sets fout=0, dir=1, load_err=0, cyc_cnt=0. Release is synchronous to the next clk edge. Reset mid-sequence discards all progress.
- Per-edge priority: clr > load > step.
- clr=1: fout=0, dir=1, cyc_cnt=0, load_err=0. Ignores load, en and mode.
- load=1 (clr=0):
  - load_val < MODULUS: fout=load_val, load_err=0.
  - Otherwise: fout=MODULUS-1, load_err=1 for exactly one cycle.
  - dir and cyc_cnt unchanged.
- Step condition: en=1, clr=0, load=0, mode!=HOLD. Otherwise fout, dir and cyc_cnt hold; load_err clears to 0 on every edge without a clamped load.
- Direction FSM, enum states UP/DOWN; dir is the state:
  - UP mode: each step sets state UP. fout = (fout==MODULUS-1) ? 0 : fout+1.
  - DOWN mode: each step sets state DOWN. fout = (fout==0) ? MODULUS-1 : fout-1.
  - PINGPONG, state UP: fout<MODULUS-1 -> fout+1; fout==MODULUS-1 -> fout=MODULUS-2, state DOWN.
  - PINGPONG, state DOWN: fout>0 -> fout-1; fout==0 -> fout=1, state UP.
  - Mode change takes effect on the next step. Entering PINGPONG keeps the current dir.
- tc=1 iff a step occurs this cycle and fout is terminal:
  - UP: fout==MODULUS-1.
  - DOWN: fout==0.
  - PINGPONG: (dir=1 and fout==MODULUS-1) or (dir=0 and fout==0).
- cyc_cnt increments on the edge where tc=1, except in PINGPONG, where it increments only at the lower turnaround (dir=0, fout==0). Saturates at 2**CYC_W-1 with no wrap.
- Arithmetic: all compares/increments are WIDTH bits. No overflow beyond MODULUS-1 is reachable. Any illegal fout >= MODULUS steps to 0 in any stepping mode.
- No X on any output after reset; default case branches assign 0 / UP.

Decomposition:
- Package fsm_seq_pkg:
  - mode_e enum (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD, 2 bits).
  - dir_e enum (DIR_DOWN=0, DIR_UP=1).
- Sub-module sat_counter (params CYC_W; ports clk, rst, clr, inc, cnt) holds cyc_cnt.
- Top holds the direction FSM, fout register and load clamp.

Test Plan (WIDTH=3, MODULUS=6):
1. Drive fout to 3, pull rst low between edges -> fout=0, dir=1, cyc_cnt=0 before the next clk edge.
2. UP, en=1, 12 steps from 0 -> fout 1,2,3,4,5,0,1,2,3,4,5,0; tc high when fout==5; cyc_cnt=2.
3. DOWN from 0, 7 steps -> fout 5,4,3,2,1,0,5; tc high at fout==0 initially and after step 6; dir=0.
4. PINGPONG from 0, dir=1, 12 steps -> 1,2,3,4,5,4,3,2,1,0,1,2; tc at fout=5 (dir 1) and fout=0 (dir 0); cyc_cnt=1 after the turnaround at 0.
5. load=1, load_val=7 -> fout=5, load_err=1 for one cycle then 0. Then load=1, load_val=2 together with clr=1 -> fout=0, load_err=0.
6. Set cyc_cnt to 255 (CYC_W=8) via repeated UP wraps -> stays 255. Then mode=HOLD or en=0 for 5 cycles -> fout, dir, cyc_cnt stable; tc=0.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared types for the programmable sequencer: stepping modes and direction states.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/fsm_seq_gen_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, cleared synchronously.
module sat_counter #(
  parameter int unsigned CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CYC_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CYC_W{1'b1}})) begin
      cnt <= cnt + CYC_W'(1);
    end
  end

endmodule

// File: rtl/fsm_seq_gen.sv
// Programmable sequencer: steps fout through 0..MODULUS-1 in up/down/ping-pong/hold modes,
// with clear, clamped parallel load, terminal-count strobe and completed-cycle count.
module fsm_seq_gen
  import fsm_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 6,
  parameter int unsigned CYC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] fout,
  output logic             dir,
  output logic             tc,
  output logic             load_err,
  output logic [CYC_W-1:0] cyc_cnt
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("fsm_seq_gen: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] FMAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] fout_q, fout_d;
  dir_e             dir_q, dir_d;
  logic             load_err_q, load_err_d;
  mode_e            mode_c;
  logic             step_c, term_c, cyc_inc_c, clamp_c;

  assign mode_c  = mode_e'(mode);
  assign step_c  = en && !clr && !load && (mode_c != MODE_HOLD);
  assign clamp_c = (32'(load_val) >= 32'(MODULUS));

  // Terminal value for the active mode; ping-pong ends depend on the travel direction.
  always_comb begin
    term_c = 1'b0;
    case (mode_c)
      MODE_UP:       term_c = (fout_q == FMAX);
      MODE_DOWN:     term_c = (fout_q == '0);
      MODE_PINGPONG: term_c = ((dir_q == DIR_UP) && (fout_q == FMAX)) ||
                              ((dir_q == DIR_DOWN) && (fout_q == '0));
      default:       term_c = 1'b0;
    endcase
  end

  assign tc = step_c && term_c;
  // Ping-pong completes a cycle only at the lower turnaround.
  assign cyc_inc_c = tc && !((mode_c == MODE_PINGPONG) && (dir_q == DIR_UP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fout_q     <= '0;
      dir_q      <= DIR_UP;
      load_err_q <= 1'b0;
    end else begin
      fout_q     <= fout_d;
      dir_q      <= dir_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    fout_d     = fout_q;
    dir_d      = dir_q;
    load_err_d = 1'b0;
    if (clr) begin
      fout_d = '0;
      dir_d  = DIR_UP;
    end else if (load) begin
      if (clamp_c) begin
        fout_d     = FMAX;
        load_err_d = 1'b1;
      end else begin
        fout_d = load_val;
      end
    end else if (step_c) begin
      case (mode_c)
        MODE_UP: begin
          dir_d  = DIR_UP;
          fout_d = (fout_q >= FMAX) ? '0 : fout_q + ONE;
        end
        MODE_DOWN: begin
          dir_d = DIR_DOWN;
          if (fout_q == '0)      fout_d = FMAX;
          else if (fout_q > FMAX) fout_d = '0;
          else                    fout_d = fout_q - ONE;
        end
        MODE_PINGPONG: begin
          if (fout_q > FMAX) begin
            fout_d = '0;
          end else if (dir_q == DIR_UP) begin
            if (fout_q == FMAX) begin
              fout_d = FMAX - ONE;
              dir_d  = DIR_DOWN;
            end else begin
              fout_d = fout_q + ONE;
            end
          end else begin
            if (fout_q == '0) begin
              fout_d = ONE;
              dir_d  = DIR_UP;
            end else begin
              fout_d = fout_q - ONE;
            end
          end
        end
        default: begin
          fout_d = '0;
          dir_d  = DIR_UP;
        end
      endcase
    end
  end

  sat_counter #(.CYC_W(CYC_W)) u_cyc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (cyc_inc_c),
    .cnt (cyc_cnt)
  );

  assign fout     = fout_q;
  assign dir      = dir_q;
  assign load_err = load_err_q;

endmodule
